mem_access_arbiter: RTL and testbench

// Parametrised arbiter sharing one multi-cycle main memory between NUM_CH requesters
// (default ch0 = I-cache, ch1 = D-cache); replaces the fixed 2-way instruction/data mux.

---
 rtl/mem_access_arbiter_pkg.sv | 16 +
 rtl/mem_access_arbiter_rr_picker.sv | 44 ++++
 rtl/mem_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the memory access arbiter: FSM state
// encoding, arbitration mode selectors and the memory word size.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_DRAIN = 2'd2,
    ST_WRITE    = 2'd3
  } arb_state_e;

  localparam int RR_FIXED   = 0;
  localparam int RR_ROUND   = 1;
  localparam int WORD_BYTES = 2;

endpackage

// File: rtl/mem_access_arbiter_rr_picker.sv
// Combinational winner selection: fixed priority (highest index wins) or
// round-robin starting one past the last winner and wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IW-1:0]     i_ptr,
  input  logic              i_rr_en,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IW-1:0]     o_idx,
  output logic              o_any
);

  always_comb begin
    logic [IW:0] cand;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    if (i_rr_en) begin
      // ptr + offset is below 2*NUM_CH, so a single subtraction wraps it
      for (int o = 1; o <= NUM_CH; o++) begin
        cand = {1'b0, i_ptr} + (IW+1)'(o);
        if (cand >= (IW+1)'(NUM_CH)) cand = cand - (IW+1)'(NUM_CH);
        if (!o_any && i_req[cand[IW-1:0]]) begin
          o_any = 1'b1;
          o_idx = cand[IW-1:0];
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_req[i]) begin
          o_any = 1'b1;
          o_idx = IW'(i);
        end
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one fixed-latency main memory between NUM_CH cache requesters:
// burst line fills, single-word writes, fixed or round-robin arbitration.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int BURST   = 8,
  parameter int RR_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [NUM_CH-1:0]    wr_i,
  input  logic [NUM_CH*AW-1:0] addr_i,
  input  logic [NUM_CH*DW-1:0] wdata_i,
  output logic [NUM_CH-1:0]    gnt_o,
  output logic [NUM_CH-1:0]    rvalid_o,
  output logic [DW-1:0]        rdata_o,
  output logic [NUM_CH-1:0]    done_o,
  output logic                 busy_o,
  output logic                 mem_en_o,
  output logic                 mem_wr_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic [DW-1:0]        mem_rdata_i,
  input  logic                 mem_valid_i,
  output logic [1:0]           dbg_state_o
);

  // Handshake: a requester raises req_i with wr_i/addr_i/wdata_i and holds
  // req_i until its done_o pulse; gnt_o marks the owner for the whole
  // transaction, rvalid_o qualifies each read beat on rdata_o, and inputs
  // are only sampled in the IDLE cycle that grants the channel.

  localparam int   IW    = $clog2(NUM_CH);
  localparam int   CW    = $clog2(BURST + 1);
  localparam logic RR_EN = (RR_MODE == RR_ROUND);

  arb_state_e      r_state;
  arb_state_e      w_next;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [AW-1:0]   r_base;
  logic [DW-1:0]   r_wdata;
  logic [CW-1:0]   r_beat;
  logic [CW-1:0]   r_ret;

  logic [NUM_CH-1:0] w_pick_gnt;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic [AW-1:0]     w_pick_addr;
  logic [DW-1:0]     w_pick_wdata;
  logic [NUM_CH-1:0] w_own_oh;
  logic [AW-1:0]     w_beat_addr;
  logic              w_rd_state;
  logic              w_issue_last;
  logic              w_ret_last;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_picker (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .i_rr_en (RR_EN),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_pick_addr  = addr_i[int'(w_pick_idx)*AW +: AW];
  assign w_pick_wdata = wdata_i[int'(w_pick_idx)*DW +: DW];

  always_comb begin
    w_own_oh          = '0;
    w_own_oh[r_owner] = 1'b1;
  end

  // Byte address of the current beat; the adder wraps modulo 2^AW
  assign w_beat_addr  = r_base + AW'(r_beat) * AW'(WORD_BYTES);
  assign w_rd_state   = (r_state == ST_RD_ISSUE) || (r_state == ST_RD_DRAIN);
  assign w_issue_last = (r_state == ST_RD_ISSUE) && (r_beat == CW'(BURST - 1));
  assign w_ret_last   = w_rd_state && mem_valid_i && (r_ret == CW'(BURST - 1));
  assign dbg_state_o  = r_state;

  always_comb begin
    w_next      = r_state;
    gnt_o       = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    done_o      = '0;
    busy_o      = 1'b0;
    mem_en_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) w_next = wr_i[w_pick_idx] ? ST_WRITE : ST_RD_ISSUE;
      end
      ST_RD_ISSUE: begin
        busy_o     = 1'b1;
        gnt_o      = w_own_oh;
        mem_en_o   = 1'b1;
        mem_addr_o = w_beat_addr;
        rvalid_o   = mem_valid_i ? w_own_oh : '0;
        rdata_o    = mem_rdata_i;
        done_o     = w_ret_last ? w_own_oh : '0;
        // A zero-latency memory can finish on the last issue cycle
        if (w_ret_last)        w_next = ST_IDLE;
        else if (w_issue_last) w_next = ST_RD_DRAIN;
      end
      ST_RD_DRAIN: begin
        busy_o   = 1'b1;
        gnt_o    = w_own_oh;
        rvalid_o = mem_valid_i ? w_own_oh : '0;
        rdata_o  = mem_rdata_i;
        done_o   = w_ret_last ? w_own_oh : '0;
        if (w_ret_last) w_next = ST_IDLE;
      end
      ST_WRITE: begin
        busy_o      = 1'b1;
        gnt_o       = w_own_oh;
        mem_en_o    = 1'b1;
        mem_wr_o    = 1'b1;
        mem_addr_o  = r_base;
        mem_wdata_o = r_wdata;
        done_o      = w_own_oh;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
      r_ptr   <= IW'(NUM_CH - 1);
      r_base  <= '0;
      r_wdata <= '0;
      r_beat  <= '0;
      r_ret   <= '0;
    end else if (r_state == ST_IDLE && w_pick_any) begin
      r_owner <= w_pick_idx;
      r_ptr   <= w_pick_idx;
      r_base  <= w_pick_addr;
      r_wdata <= w_pick_wdata;
      r_beat  <= '0;
      r_ret   <= '0;
    end else begin
      if (r_state == ST_RD_ISSUE && !w_issue_last) r_beat <= r_beat + CW'(1);
      if (w_rd_state && mem_valid_i && r_ret != CW'(BURST)) r_ret <= r_ret + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: three configurations, each with a
// fixed-latency memory model; expectations are queued by the drivers.
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: 2 ch, fixed, BURST 8 ----------------
  logic [1:0]  a_req = '0, a_wr = '0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [1:0]  a_gnt, a_rvalid, a_done, a_dbg;
  logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_busy, a_mem_en, a_mem_wr, a_mem_valid;
  logic        a_spur = 1'b0;
  logic [3:0]  a_pv;
  logic [15:0] a_pd [4];

  mem_access_arbiter #(.NUM_CH(2), .AW(16), .DW(16), .BURST(8), .RR_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(a_req), .wr_i(a_wr), .addr_i(a_addr),
    .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
    .done_o(a_done), .busy_o(a_busy), .mem_en_o(a_mem_en), .mem_wr_o(a_mem_wr),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata),
    .mem_valid_i(a_mem_valid), .dbg_state_o(a_dbg));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pv <= '0;
      for (int i = 0; i < 4; i++) a_pd[i] <= '0;
    end else begin
      a_pv    <= {a_pv[2:0], a_mem_en & ~a_mem_wr};
      a_pd[0] <= a_mem_addr ^ 16'h5A5A;
      for (int i = 1; i < 4; i++) a_pd[i] <= a_pd[i-1];
    end
  end
  assign a_mem_valid = a_pv[3] | a_spur;
  assign a_mem_rdata = a_spur ? 16'hDEAD : a_pd[3];

  // ---------------- instance B: 4 ch, round-robin ----------------
  logic [3:0]  b_req = '0, b_wr = '0;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_gnt, b_rvalid, b_done;
  logic [1:0]  b_dbg;
  logic [15:0] b_rdata, b_mem_addr, b_mem_wdata;
  logic [15:0] b_mem_rdata = '0;
  logic        b_mem_valid = 1'b0;
  logic        b_busy, b_mem_en, b_mem_wr;

  mem_access_arbiter #(.NUM_CH(4), .AW(16), .DW(16), .BURST(8), .RR_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(b_req), .wr_i(b_wr), .addr_i(b_addr),
    .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
    .done_o(b_done), .busy_o(b_busy), .mem_en_o(b_mem_en), .mem_wr_o(b_mem_wr),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
    .mem_valid_i(b_mem_valid), .dbg_state_o(b_dbg));

  // ---------------- instance C: 2 ch, fixed, BURST 4 ----------------
  logic [1:0]  c_req = '0, c_wr = '0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [1:0]  c_gnt, c_rvalid, c_done, c_dbg;
  logic [15:0] c_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic        c_busy, c_mem_en, c_mem_wr, c_mem_valid;
  logic [3:0]  c_pv;
  logic [15:0] c_pd [4];

  mem_access_arbiter #(.NUM_CH(2), .AW(16), .DW(16), .BURST(4), .RR_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_i(c_req), .wr_i(c_wr), .addr_i(c_addr),
    .wdata_i(c_wdata), .gnt_o(c_gnt), .rvalid_o(c_rvalid), .rdata_o(c_rdata),
    .done_o(c_done), .busy_o(c_busy), .mem_en_o(c_mem_en), .mem_wr_o(c_mem_wr),
    .mem_addr_o(c_mem_addr), .mem_wdata_o(c_mem_wdata), .mem_rdata_i(c_mem_rdata),
    .mem_valid_i(c_mem_valid), .dbg_state_o(c_dbg));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_pv <= '0;
      for (int i = 0; i < 4; i++) c_pd[i] <= '0;
    end else begin
      c_pv    <= {c_pv[2:0], c_mem_en & ~c_mem_wr};
      c_pd[0] <= c_mem_addr ^ 16'h5A5A;
      for (int i = 1; i < 4; i++) c_pd[i] <= c_pd[i-1];
    end
  end
  assign c_mem_valid = c_pv[3];
  assign c_mem_rdata = c_pd[3];

  // ---------------- scoreboard queues ----------------
  logic [63:0] a_iss_q[$], a_ret_q[$], a_done_q[$];
  logic [63:0] b_iss_q[$], b_done_q[$];
  logic [63:0] c_iss_q[$], c_ret_q[$], c_done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [63:0] a_outs();
    return 64'({a_gnt, a_rvalid, a_rdata, a_done, a_busy, a_mem_en, a_mem_wr,
                a_mem_addr, a_mem_wdata});
  endfunction

  function automatic logic [63:0] b_outs();
    return 64'({b_gnt, b_rvalid, b_rdata, b_done, b_busy, b_mem_en, b_mem_wr,
                b_mem_addr, b_mem_wdata});
  endfunction

  function automatic logic [63:0] c_outs();
    return 64'({c_gnt, c_rvalid, c_rdata, c_done, c_busy, c_mem_en, c_mem_wr,
                c_mem_addr, c_mem_wdata});
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (a_mem_en) begin
          if (a_iss_q.size() == 0) unexp("a_issue", 64'({a_mem_wr, a_mem_addr, a_mem_wdata}));
          else chk("a_issue", 64'({a_mem_wr, a_mem_addr, a_mem_wdata}), a_iss_q.pop_front());
        end
        if (a_rvalid != 0) begin
          if (a_ret_q.size() == 0) unexp("a_rvalid", 64'({a_rvalid, a_rdata}));
          else chk("a_rvalid", 64'({a_rvalid, a_rdata}), a_ret_q.pop_front());
        end
        if (a_done != 0) begin
          if (a_done_q.size() == 0) unexp("a_done", 64'({32'(cyc), a_gnt, a_done}));
          else chk("a_done", 64'({32'(cyc), a_gnt, a_done}), a_done_q.pop_front());
        end
        if (b_mem_en) begin
          if (b_iss_q.size() == 0) unexp("b_issue", 64'({b_mem_wr, b_mem_addr, b_mem_wdata}));
          else chk("b_issue", 64'({b_mem_wr, b_mem_addr, b_mem_wdata}), b_iss_q.pop_front());
        end
        if (b_done != 0) begin
          if (b_done_q.size() == 0) unexp("b_done", 64'({32'(cyc), b_gnt, b_done}));
          else chk("b_done", 64'({32'(cyc), b_gnt, b_done}), b_done_q.pop_front());
        end
        if (c_mem_en) begin
          if (c_iss_q.size() == 0) unexp("c_issue", 64'({c_mem_wr, c_mem_addr, c_mem_wdata}));
          else chk("c_issue", 64'({c_mem_wr, c_mem_addr, c_mem_wdata}), c_iss_q.pop_front());
        end
        if (c_rvalid != 0) begin
          if (c_ret_q.size() == 0) unexp("c_rvalid", 64'({c_rvalid, c_rdata}));
          else chk("c_rvalid", 64'({c_rvalid, c_rdata}), c_ret_q.pop_front());
        end
        if (c_done != 0) begin
          if (c_done_q.size() == 0) unexp("c_done", 64'({32'(cyc), c_gnt, c_done}));
          else chk("c_done", 64'({32'(cyc), c_gnt, c_done}), c_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Burst of 8 on A; 'start' is the IDLE cycle in which the request is seen.
  task automatic push_a_read(input int ch, input logic [15:0] base, input int start);
    logic [15:0] ad;
    logic [1:0]  v;
    v = 2'(1 << ch);
    for (int k = 0; k < 8; k++) begin
      ad = base + 16'(2 * k);
      a_iss_q.push_back(64'({1'b0, ad, 16'h0000}));
      a_ret_q.push_back(64'({v, ad ^ 16'h5A5A}));
    end
    a_done_q.push_back(64'({32'(start + 12), v, v}));
  endtask

  task automatic a_wait(input int budget);
    int n;
    n = 0;
    while (a_req != 0 && n < budget) begin
      @(negedge clk);
      n++;
      for (int k = 0; k < 2; k++) if (a_done[k]) a_req[k] = 1'b0;
    end
    chk("a_timeout", 64'(a_req), 64'(0));
    a_req = '0;
    a_wr  = '0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt;
    int ord [5];
    logic [15:0] c_tab [4];
    ord   = '{0, 1, 2, 3, 0};
    c_tab = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_outs", a_outs(), 64'(0));
    chk("rst_b_outs", b_outs(), 64'(0));
    chk("rst_c_outs", c_outs(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_a_state", 64'(a_dbg), 64'(ST_IDLE));
    chk("idle_a_outs", a_outs(), 64'(0));

    // ch0 read alone, base 0x0010
    n = cyc;
    a_addr = {16'h0000, 16'h0010};
    a_req  = 2'b01;
    push_a_read(0, 16'h0010, n);
    a_wait(40);

    // Simultaneous requests: ch1 first, ch0 after one IDLE cycle
    n = cyc;
    a_addr = {16'h0100, 16'h0200};
    a_req  = 2'b11;
    push_a_read(1, 16'h0100, n);
    push_a_read(0, 16'h0200, n + 13);
    a_wait(60);

    // ch1 single-word write
    n = cyc;
    a_addr  = {16'hFFFE, 16'h0000};
    a_wdata = {16'hBEEF, 16'h0000};
    a_wr    = 2'b10;
    a_req   = 2'b10;
    a_iss_q.push_back(64'({1'b1, 16'hFFFE, 16'hBEEF}));
    a_done_q.push_back(64'({32'(n + 1), 2'b10, 2'b10}));
    a_wait(10);

    // Reset in the cycle that presents beat 3: beats 0..2 seen, no done
    a_addr = {16'h0000, 16'h0300};
    a_req  = 2'b01;
    push_a_read(0, 16'h0300, cyc);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_a_outs", a_outs(), 64'(0));
    chk("abort_a_state", 64'(a_dbg), 64'(ST_IDLE));
    chk("abort_beats_left", 64'(a_iss_q.size()), 64'(5));
    a_iss_q.delete();
    a_ret_q.delete();
    a_done_q.delete();
    a_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Spurious mem_valid_i while IDLE, then a clean burst of exactly 8
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 a_spur = 1'b1;
      @(negedge clk);
      chk("spur_rvalid", 64'({a_rvalid, a_rdata}), 64'(0));
    end
    @(posedge clk);
    #1 a_spur = 1'b0;
    @(negedge clk);
    n = cyc;
    a_addr = {16'h0000, 16'h0040};
    a_req  = 2'b01;
    push_a_read(0, 16'h0040, n);
    a_wait(40);

    // Round-robin, four channels all holding write requests
    n = cyc;
    b_addr  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    b_wdata = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    b_wr    = 4'hF;
    b_req   = 4'hF;
    for (int k = 0; k < 5; k++) begin
      b_iss_q.push_back(64'({1'b1, 16'h1000 + 16'(ord[k]), 16'hD000 + 16'(ord[k])}));
      b_done_q.push_back(64'({32'(n + 1 + 2 * k), 4'(1 << ord[k]), 4'(1 << ord[k])}));
    end
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 5; k++) begin
      @(negedge clk);
      if (b_done != 0) cnt++;
      if (cnt == 5) b_req = '0;
    end
    chk("b_done_count", 64'(cnt), 64'(5));
    b_req = '0;
    @(negedge clk);

    // BURST=4 read wrapping past 0xFFFF
    n = cyc;
    c_addr = {16'h0000, 16'hFFFC};
    c_req  = 2'b01;
    for (int k = 0; k < 4; k++) begin
      c_iss_q.push_back(64'({1'b0, c_tab[k], 16'h0000}));
      c_ret_q.push_back(64'({2'b01, c_tab[k] ^ 16'h5A5A}));
    end
    c_done_q.push_back(64'({32'(n + 8), 2'b01, 2'b01}));
    cnt = 0;
    for (int k = 0; k < 30 && c_req != 0; k++) begin
      @(negedge clk);
      if (c_done[0]) c_req = '0;
    end
    chk("c_timeout", 64'(c_req), 64'(0));
    c_req = '0;
    repeat (3) @(negedge clk);

    // Every queued expectation must have been consumed
    chk("a_iss_left",  64'(a_iss_q.size()),  64'(0));
    chk("a_ret_left",  64'(a_ret_q.size()),  64'(0));
    chk("a_done_left", 64'(a_done_q.size()), 64'(0));
    chk("b_iss_left",  64'(b_iss_q.size()),  64'(0));
    chk("b_done_left", 64'(b_done_q.size()), 64'(0));
    chk("c_iss_left",  64'(c_iss_q.size()),  64'(0));
    chk("c_ret_left",  64'(c_ret_q.size()),  64'(0));
    chk("c_done_left", 64'(c_done_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
